id_ex_pipeline_reg: RTL

//  Decode-to-execute pipeline register. Sits directly downstream of the register file.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/id_ex_pipeline_reg_if.sv | 51 +++++
 rtl/id_ex_pipeline_reg_operand_bypass.sv | 29 ++
 rtl/id_ex_pipeline_reg.sv | 108 ++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the decode/execute boundary: bus widths, the
// hard-wired zero register and the layout of the decoded control bundle.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int IMM_W  = 16;
  localparam int CTRL_W = 12;

  // Register 0 always reads as zero and is never a bypass source.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Bit positions inside the control bundle. The ID/EX stage only carries
  // the bundle; execute and later stages decode these fields.
  localparam int CTRL_REGWRITE_BIT = 0;
  localparam int CTRL_MEMREAD_BIT  = 1;
  localparam int CTRL_MEMWRITE_BIT = 2;
  localparam int CTRL_MEMTOREG_BIT = 3;
  localparam int CTRL_BRANCH_BIT   = 4;
  localparam int CTRL_ALUSRC_BIT   = 5;
  localparam int CTRL_REGDST_BIT   = 6;
  localparam int CTRL_ALUOP_LSB    = 7;
  localparam int CTRL_ALUOP_W      = 4;
  localparam int CTRL_JUMP_BIT     = 11;

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// Bundle of every signal crossing the ID/EX pipeline register: the decode
// side handshake and fields, the write-back snoop and the execute side.
interface id_ex_pipeline_reg_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int IMM_W  = mips_pkg::IMM_W,
  parameter int CTRL_W = mips_pkg::CTRL_W
);
  import mips_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [IMM_W-1:0]  imm;
  logic              imm_zext;
  logic [CTRL_W-1:0] ctrl;
  logic              wb_regwrite;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rs_data;
  logic [DATA_W-1:0] out_rt_data;
  logic [DATA_W-1:0] out_imm;
  logic [ADDR_W-1:0] out_rs_addr;
  logic [ADDR_W-1:0] out_rt_addr;
  logic [ADDR_W-1:0] out_rd_addr;
  logic [CTRL_W-1:0] out_ctrl;

  // Surrounding pipeline: drives decode, write-back and execute-ready.
  modport master (
    output in_valid, flush, rs_addr, rt_addr, rd_addr, rs_data, rt_data,
           imm, imm_zext, ctrl, wb_regwrite, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm,
           out_rs_addr, out_rt_addr, out_rd_addr, out_ctrl
  );

  // The pipeline register itself.
  modport slave (
    input  in_valid, flush, rs_addr, rt_addr, rd_addr, rs_data, rt_data,
           imm, imm_zext, ctrl, wb_regwrite, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_rs_data, out_rt_data, out_imm,
           out_rs_addr, out_rt_addr, out_rd_addr, out_ctrl
  );

endinterface

// File: rtl/id_ex_pipeline_reg_operand_bypass.sv
// Operand selector: register 0 forces zero, a matching write-back wins over
// the supplied value, otherwise the supplied value passes through.
module operand_bypass #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wbRegwrite,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0] wbData,
  output logic [DATA_W-1:0] result
);
  import mips_pkg::*;

  logic [ADDR_W-1:0] zeroAddr;
  assign zeroAddr = ADDR_W'(REG_ZERO);

  // Zero register first, then write-back forwarding, then the plain value.
  always_comb begin
    result = data;
    if (addr == zeroAddr) begin
      result = '0;
    end else if (wbRegwrite && (wbAddr == addr)) begin
      result = wbData;
    end
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register: single entry with valid/ready on both
// sides, flush, immediate extension, capture-time write-back forwarding and
// forwarding into held operands while execute stalls.
module id_ex_pipeline_reg #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int IMM_W  = mips_pkg::IMM_W,
  parameter int CTRL_W = mips_pkg::CTRL_W
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_pipeline_reg_if.slave bus
);
  import mips_pkg::*;

  logic              outValid_p1;
  logic [DATA_W-1:0] outRsData_p1;
  logic [DATA_W-1:0] outRtData_p1;
  logic [DATA_W-1:0] outImm_p1;
  logic [ADDR_W-1:0] outRsAddr_p1;
  logic [ADDR_W-1:0] outRtAddr_p1;
  logic [ADDR_W-1:0] outRdAddr_p1;
  logic [CTRL_W-1:0] outCtrl_p1;

  logic              inReady;
  logic              capture;
  logic [DATA_W-1:0] capRsData;
  logic [DATA_W-1:0] capRtData;
  logic [DATA_W-1:0] holdRsData;
  logic [DATA_W-1:0] holdRtData;

  // Sign or zero extension: the fill bit is the immediate's MSB unless
  // zero extension is requested.
  function automatic logic [DATA_W-1:0] extendImm(input logic [IMM_W-1:0] raw,
                                                  input logic             zext);
    logic fill;
    fill = raw[IMM_W-1] & ~zext;
    return {{(DATA_W-IMM_W){fill}}, raw};
  endfunction

  // Accept whenever the slot is empty or is being consumed this cycle;
  // flush deliberately does not gate this.
  assign inReady = !outValid_p1 || bus.out_ready;
  assign capture = bus.in_valid && inReady;

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uCapRs (
    .addr(bus.rs_addr), .data(bus.rs_data), .wbRegwrite(bus.wb_regwrite),
    .wbAddr(bus.wb_addr), .wbData(bus.wb_data), .result(capRsData)
  );

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uCapRt (
    .addr(bus.rt_addr), .data(bus.rt_data), .wbRegwrite(bus.wb_regwrite),
    .wbAddr(bus.wb_addr), .wbData(bus.wb_data), .result(capRtData)
  );

  // Held operands re-resolved against write-back so a stalled entry never
  // goes stale relative to the register file.
  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uHoldRs (
    .addr(outRsAddr_p1), .data(outRsData_p1), .wbRegwrite(bus.wb_regwrite),
    .wbAddr(bus.wb_addr), .wbData(bus.wb_data), .result(holdRsData)
  );

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uHoldRt (
    .addr(outRtAddr_p1), .data(outRtData_p1), .wbRegwrite(bus.wb_regwrite),
    .wbAddr(bus.wb_addr), .wbData(bus.wb_data), .result(holdRtData)
  );

  // ---- Stage p1: ID/EX register (flush > capture > drain > hold) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_p1  <= 1'b0;
      outRsData_p1 <= '0;
      outRtData_p1 <= '0;
      outImm_p1    <= '0;
      outRsAddr_p1 <= '0;
      outRtAddr_p1 <= '0;
      outRdAddr_p1 <= '0;
      outCtrl_p1   <= '0;
    end else if (bus.flush) begin
      outValid_p1 <= 1'b0;
    end else if (capture) begin
      outValid_p1  <= 1'b1;
      outRsData_p1 <= capRsData;
      outRtData_p1 <= capRtData;
      outImm_p1    <= extendImm(bus.imm, bus.imm_zext);
      outRsAddr_p1 <= bus.rs_addr;
      outRtAddr_p1 <= bus.rt_addr;
      outRdAddr_p1 <= bus.rd_addr;
      outCtrl_p1   <= bus.ctrl;
    end else if (outValid_p1 && bus.out_ready) begin
      outValid_p1 <= 1'b0;
    end else if (outValid_p1) begin
      outRsData_p1 <= holdRsData;
      outRtData_p1 <= holdRtData;
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.out_valid   = outValid_p1;
  assign bus.out_rs_data = outRsData_p1;
  assign bus.out_rt_data = outRtData_p1;
  assign bus.out_imm     = outImm_p1;
  assign bus.out_rs_addr = outRsAddr_p1;
  assign bus.out_rt_addr = outRtAddr_p1;
  assign bus.out_rd_addr = outRdAddr_p1;
  assign bus.out_ctrl    = outCtrl_p1;

endmodule
